// File: rtl/fsquare_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fsquare_seq : iterative IEEE-754 single squarer (y = x*x), shift-add datapath
// Revision    : 1.0
// ----------------------------------------------------------------------------
module fsquare_seq #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  localparam int STEPS = 24 / RADIX_BITS;

  if (RADIX_BITS != 1 && RADIX_BITS != 2 && RADIX_BITS != 4 && RADIX_BITS != 8) begin : g_bad_radix
    $error("fsquare_seq: RADIX_BITS must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  e;
  logic [22:0] frac;
  logic [23:0] mq;      // multiplier bits not yet retired
  logic [47:0] mc;      // multiplicand aligned to the current bit position
  logic [47:0] p;
  logic [4:0]  cnt;

  logic [47:0]        p_next;
  logic signed [10:0] ex;
  logic [22:0]        mant;
  logic [31:0]        result;
  logic               unused_sign;

  assign unused_sign = x[31];

  always_comb begin
    p_next = p;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mq[i]) p_next = p_next + (mc << i);
    end
  end

  always_comb begin
    ex   = $signed({2'b00, e, 1'b0}) - (p[47] ? 11'sd126 : 11'sd127);
    mant = p[47] ? p[46:24] : p[45:23];
    if (e == 8'd0)
      result = 32'h0000_0000;
    else if (e == 8'hFF)
      result = (frac != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    else if (ex >= 11'sd255)
      result = 32'h7F80_0000;
    else if (ex <= 11'sd0)
      result = 32'h0000_0000;
    else
      result = {1'b0, ex[7:0], mant};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= 32'h0;
      e         <= 8'd0;
      frac      <= 23'd0;
      mq        <= 24'd0;
      mc        <= 48'd0;
      p         <= 48'd0;
      cnt       <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            e        <= x[30:23];
            frac     <= x[22:0];
            mq       <= {1'b1, x[22:0]};
            mc       <= {24'd0, 1'b1, x[22:0]};
            p        <= 48'd0;
            cnt      <= 5'(STEPS);
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          // The extra cycle spent seeing cnt==0 keeps latency at STEPS+2.
          if (cnt != 5'd0) begin
            p   <= p_next;
            mc  <= mc << RADIX_BITS;
            mq  <= mq >> RADIX_BITS;
            cnt <= cnt - 5'd1;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          y         <= result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
